// File: rtl/staged_reset_gen.sv
// Staged active-low reset generator: lock filter, hold count, then in-order stage release.
// Optional lock-loss event counter is enabled by defining STAGED_RST_LOSS_CNT_EN.
module staged_reset_gen #(
  parameter int N_STAGES   = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int STAGE_GAP  = 8,
  parameter int FILTER_LEN = 4
) (
  input  logic                clk_i,
  input  logic                rst_n,
  input  logic                locked_i,
  input  logic                soft_rst_req_i,
  output logic                soft_rst_ack_o,
  output logic [N_STAGES-1:0] rst_out_n,
  output logic                rst_out_p,
  output logic                all_done_o,
  output logic [1:0]          state_o
`ifdef STAGED_RST_LOSS_CNT_EN
  , output logic [7:0]        lock_loss_cnt_o
`endif
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam int IW = $clog2(N_STAGES + 1);

  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
  // Index of the stage released just before the final one; unused when N_STAGES==1.
  localparam logic [IW-1:0] IDX_LAST  = IW'((N_STAGES > 1) ? N_STAGES - 2 : 0);
  localparam logic [N_STAGES-1:0] STG_ONE = N_STAGES'(1);

  localparam logic [1:0] S_HOLD  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_STAGE = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  logic [1:0]           state;
  logic [FW-1:0]        filt;
  logic [GW-1:0]        gap;
  logic [IW-1:0]        idx;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 soft_armed;

  assign state_o   = state;
  assign rst_out_p = ~&rst_out_n;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_HOLD;
      filt           <= '0;
      gap            <= '0;
      idx            <= '0;
      cnt            <= '0;
      soft_armed     <= 1'b1;
      soft_rst_ack_o <= 1'b0;
      rst_out_n      <= '0;
      all_done_o     <= 1'b0;
    end else begin
      soft_rst_ack_o <= 1'b0;
      if (!soft_rst_req_i) soft_armed <= 1'b1;
      // Lock loss overrides everything, including a same-cycle soft request.
      if (!locked_i) begin
        state      <= S_HOLD;
        filt       <= '0;
        rst_out_n  <= '0;
        all_done_o <= 1'b0;
      end else begin
        case (state)
          S_HOLD: begin
            if (filt == FILT_LAST) begin
              state <= S_COUNT;
              filt  <= '0;
              cnt   <= '0;
            end else begin
              filt <= filt + 1'b1;
            end
          end
          S_COUNT: begin
            if (cnt == '1) begin
              cnt       <= '0;
              gap       <= '0;
              idx       <= '0;
              rst_out_n <= STG_ONE;
              if (N_STAGES == 1) begin
                state      <= S_RUN;
                all_done_o <= 1'b1;
              end else begin
                state <= S_STAGE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_STAGE: begin
            if (gap == GAP_LAST) begin
              gap <= '0;
              idx <= idx + 1'b1;
              // Releases are strictly in order, so the vector stays a thermometer code.
              rst_out_n <= (rst_out_n << 1) | STG_ONE;
              if (idx == IDX_LAST) begin
                state      <= S_RUN;
                all_done_o <= 1'b1;
              end
            end else begin
              gap <= gap + 1'b1;
            end
          end
          default: begin
            if (soft_rst_req_i && soft_armed) begin
              state          <= S_COUNT;
              cnt            <= '0;
              rst_out_n      <= '0;
              all_done_o     <= 1'b0;
              soft_rst_ack_o <= 1'b1;
              soft_armed     <= 1'b0;
            end
          end
        endcase
      end
    end
  end

`ifdef STAGED_RST_LOSS_CNT_EN
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)
      lock_loss_cnt_o <= 8'h00;
    else if (!locked_i && state != S_HOLD && lock_loss_cnt_o != 8'hFF)
      lock_loss_cnt_o <= lock_loss_cnt_o + 8'd1;
  end
`else
  // Build without the lock-loss counter: no extra port or state.
`endif

endmodule

// File: tb/tb_staged_reset_gen.sv
// Directed bench for staged_reset_gen (N_STAGES=4 CNT_WIDTH=4 STAGE_GAP=8 FILTER_LEN=4).
module tb_staged_reset_gen;
  logic       clk_i = 1'b0;
  logic       rst_n = 1'b0;
  logic       locked_i = 1'b0;
  logic       soft_rst_req_i = 1'b0;
  logic       soft_rst_ack_o;
  logic [3:0] rst_out_n;
  logic       rst_out_p;
  logic       all_done_o;
  logic [1:0] state_o;
`ifdef STAGED_RST_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt_o;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk_i = ~clk_i;

  staged_reset_gen #(.N_STAGES(4), .CNT_WIDTH(4), .STAGE_GAP(8), .FILTER_LEN(4)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .locked_i(locked_i), .soft_rst_req_i(soft_rst_req_i),
    .soft_rst_ack_o(soft_rst_ack_o), .rst_out_n(rst_out_n), .rst_out_p(rst_out_p),
    .all_done_o(all_done_o), .state_o(state_o)
`ifdef STAGED_RST_LOSS_CNT_EN
    , .lock_loss_cnt_o(lock_loss_cnt_o)
`endif
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    step(); step();
    total++; if (rst_out_n !== 4'h0) $display("FAIL reset_rst_out_n got=%h exp=0", rst_out_n); else passed++;
    total++; if (rst_out_p !== 1'b1) $display("FAIL reset_rst_out_p got=%b exp=1", rst_out_p); else passed++;
    total++; if (all_done_o !== 1'b0) $display("FAIL reset_done got=%b exp=0", all_done_o); else passed++;
    total++; if (soft_rst_ack_o !== 1'b0) $display("FAIL reset_ack got=%b exp=0", soft_rst_ack_o); else passed++;
    total++; if (state_o !== 2'd0) $display("FAIL reset_state got=%0d exp=0", state_o); else passed++;
`ifdef STAGED_RST_LOSS_CNT_EN
    total++; if (lock_loss_cnt_o !== 8'h00) $display("FAIL reset_loss_cnt got=%h exp=0", lock_loss_cnt_o); else passed++;
`endif
  endtask

  // Edge 1 is the first edge sampling locked_i=1.
  task automatic test_power_up();
    logic [3:0] exp_r;
    logic [1:0] exp_s;
    rst_n = 1'b1;
    locked_i = 1'b1;
    for (int e = 1; e <= 44; e++) begin
      step();
      exp_r = (e >= 44) ? 4'hF : (e >= 36) ? 4'h7 : (e >= 28) ? 4'h3 : (e >= 20) ? 4'h1 : 4'h0;
      exp_s = (e >= 44) ? 2'd3 : (e >= 20) ? 2'd2 : (e >= 4) ? 2'd1 : 2'd0;
      total++; if (rst_out_n !== exp_r) $display("FAIL pu_rst_out_n edge=%0d got=%h exp=%h", e, rst_out_n, exp_r); else passed++;
      total++; if (state_o !== exp_s) $display("FAIL pu_state edge=%0d got=%0d exp=%0d", e, state_o, exp_s); else passed++;
      total++; if (rst_out_p !== (exp_r != 4'hF)) $display("FAIL pu_rst_out_p edge=%0d got=%b", e, rst_out_p); else passed++;
      total++; if (all_done_o !== (e >= 44)) $display("FAIL pu_done edge=%0d got=%b", e, all_done_o); else passed++;
    end
  endtask

  task automatic test_soft_reset();
    int acks = 0;
    soft_rst_req_i = 1'b1;
    for (int i = 1; i <= 48; i++) begin
      step();
      if (soft_rst_ack_o === 1'b1) acks++;
      if (i == 1) begin
        total++; if (soft_rst_ack_o !== 1'b1) $display("FAIL soft_ack got=%b exp=1", soft_rst_ack_o); else passed++;
        total++; if (rst_out_n !== 4'h0) $display("FAIL soft_rst_out_n got=%h exp=0", rst_out_n); else passed++;
        total++; if (state_o !== 2'd1) $display("FAIL soft_state got=%0d exp=1", state_o); else passed++;
        total++; if (all_done_o !== 1'b0) $display("FAIL soft_done got=%b exp=0", all_done_o); else passed++;
      end
      if (i == 2) begin
        total++; if (soft_rst_ack_o !== 1'b0) $display("FAIL soft_ack_width got=%b exp=0", soft_rst_ack_o); else passed++;
      end
      if (i == 16) begin
        total++; if (rst_out_n !== 4'h0) $display("FAIL soft_pre_release got=%h exp=0", rst_out_n); else passed++;
      end
      if (i == 17) begin
        total++; if (rst_out_n !== 4'h1) $display("FAIL soft_bit0 got=%h exp=1", rst_out_n); else passed++;
      end
    end
    total++; if (acks !== 1) $display("FAIL soft_ack_count got=%0d exp=1", acks); else passed++;
    total++; if (state_o !== 2'd3) $display("FAIL soft_back_run got=%0d exp=3", state_o); else passed++;
    soft_rst_req_i = 1'b0;
    step();
  endtask

  task automatic test_glitch();
    locked_i = 1'b0;
    step();
    total++; if (state_o !== 2'd0) $display("FAIL run_loss_state got=%0d exp=0", state_o); else passed++;
    total++; if (rst_out_n !== 4'h0) $display("FAIL run_loss_rst got=%h exp=0", rst_out_n); else passed++;
    locked_i = 1'b1;
    repeat (3) step();
    locked_i = 1'b0;
    step();
    locked_i = 1'b1;
    for (int e = 1; e <= 28; e++) begin
      step();
      if (e == 17 || e == 19) begin
        total++; if (rst_out_n !== 4'h0) $display("FAIL glitch_early edge=%0d got=%h exp=0", e, rst_out_n); else passed++;
      end
      if (e == 20) begin
        total++; if (rst_out_n !== 4'h1) $display("FAIL glitch_bit0 got=%h exp=1", rst_out_n); else passed++;
      end
    end
    total++; if (rst_out_n !== 4'h3 || state_o !== 2'd2) $display("FAIL stage_pre_loss got=%h/%0d exp=3/2", rst_out_n, state_o); else passed++;
  endtask

  task automatic test_stage_loss();
    locked_i = 1'b0;
    step();
    total++; if (rst_out_n !== 4'h0) $display("FAIL stage_loss_rst got=%h exp=0", rst_out_n); else passed++;
    total++; if (state_o !== 2'd0) $display("FAIL stage_loss_state got=%0d exp=0", state_o); else passed++;
    total++; if (rst_out_p !== 1'b1) $display("FAIL stage_loss_p got=%b exp=1", rst_out_p); else passed++;
  endtask

  task automatic test_pending_request();
    int acks = 0;
    int budget = 0;
    soft_rst_req_i = 1'b1;
    locked_i = 1'b1;
    for (int e = 1; e <= 44; e++) begin
      step();
      if (soft_rst_ack_o === 1'b1) acks++;
    end
    total++; if (acks !== 0) $display("FAIL pending_early_ack got=%0d exp=0", acks); else passed++;
    total++; if (state_o !== 2'd3) $display("FAIL pending_run got=%0d exp=3", state_o); else passed++;
    step();
    total++; if (soft_rst_ack_o !== 1'b1 || state_o !== 2'd1) $display("FAIL pending_accept got=%b/%0d exp=1/1", soft_rst_ack_o, state_o); else passed++;
    soft_rst_req_i = 1'b0;
    while (state_o !== 2'd3 && budget < 60) begin
      step();
      budget++;
    end
    total++; if (state_o !== 2'd3) $display("FAIL pending_rerun_timeout got=%0d exp=3", state_o); else passed++;
  endtask

  task automatic test_same_cycle();
    soft_rst_req_i = 1'b1;
    locked_i = 1'b0;
    step();
    total++; if (state_o !== 2'd0) $display("FAIL same_state got=%0d exp=0", state_o); else passed++;
    total++; if (soft_rst_ack_o !== 1'b0) $display("FAIL same_ack got=%b exp=0", soft_rst_ack_o); else passed++;
    total++; if (rst_out_n !== 4'h0 || all_done_o !== 1'b0) $display("FAIL same_outs got=%h/%b exp=0/0", rst_out_n, all_done_o); else passed++;
    soft_rst_req_i = 1'b0;
  endtask

  task automatic test_async_reset();
    locked_i = 1'b1;
    repeat (10) step();
    total++; if (state_o !== 2'd1) $display("FAIL ar_pre_state got=%0d exp=1", state_o); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (state_o !== 2'd0) $display("FAIL ar_state got=%0d exp=0", state_o); else passed++;
    total++; if (rst_out_n !== 4'h0 || rst_out_p !== 1'b1) $display("FAIL ar_rst got=%h/%b exp=0/1", rst_out_n, rst_out_p); else passed++;
    total++; if (all_done_o !== 1'b0 || soft_rst_ack_o !== 1'b0) $display("FAIL ar_flags got=%b/%b exp=0/0", all_done_o, soft_rst_ack_o); else passed++;
  endtask

`ifdef STAGED_RST_LOSS_CNT_EN
  task automatic test_loss_cnt();
    locked_i = 1'b0;
    step();
    rst_n = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      locked_i = 1'b1;
      repeat (4) step();
      locked_i = 1'b0;
      step();
      if (n == 1) begin
        total++; if (lock_loss_cnt_o !== 8'h01) $display("FAIL loss_cnt_first got=%h exp=01", lock_loss_cnt_o); else passed++;
      end
      if (n == 254) begin
        total++; if (lock_loss_cnt_o !== 8'hFE) $display("FAIL loss_cnt_254 got=%h exp=FE", lock_loss_cnt_o); else passed++;
      end
    end
    step();
    total++; if (lock_loss_cnt_o !== 8'hFF) $display("FAIL loss_cnt_sat got=%h exp=FF", lock_loss_cnt_o); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_power_up();
    test_soft_reset();
    test_glitch();
    test_stage_loss();
    test_pending_request();
    test_same_cycle();
    test_async_reset();
`ifdef STAGED_RST_LOSS_CNT_EN
    test_loss_cnt();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
